// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and helpers for the MEM-stage data memory
package mem_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } mem_state_e;

    // Reserved size is reported through the same error path as a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = lane[0];
            SIZE_WORD: bad = (lane != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane shift / byte enables and load extract / extension
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [1:0]        lane,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rword,
    output logic [DATA_W-1:0] wdata_lane,
    output logic [3:0]        byte_en,
    output logic [DATA_W-1:0] rdata_ext
);

    logic [4:0]        shamt;
    logic [DATA_W-1:0] rshift;

    assign shamt      = {lane, 3'b000};
    assign wdata_lane = wdata << shamt;
    assign rshift     = rword >> shamt;

    always_comb begin
        byte_en   = 4'b0000;
        rdata_ext = '0;
        case (size)
            SIZE_BYTE: begin
                byte_en   = 4'b0001 << lane;
                rdata_ext = {{24{~unsigned_ld & rshift[7]}}, rshift[7:0]};
            end
            SIZE_HALF: begin
                byte_en   = 4'b0011 << lane;
                rdata_ext = {{16{~unsigned_ld & rshift[15]}}, rshift[15:0]};
            end
            SIZE_WORD: begin
                byte_en   = 4'b1111;
                rdata_ext = rword;
            end
            default: begin
                byte_en   = 4'b0000;
                rdata_ext = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_stage.sv
// rtl/data_mem_stage.sv - MEM-stage data memory with valid/ready request and response
module data_mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int DEPTH    = 2 ** (ADDR_W - 2);
    localparam int CNT_LAST = (LATENCY > 1) ? LATENCY - 2 : 0;

    logic [DATA_W-1:0] mem [DEPTH];

    mem_state_e        state;
    logic [1:0]        cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              accept;
    logic [ADDR_W-3:0] idx;
    logic [1:0]        lane;
    logic              misaligned;
    logic [DATA_W-1:0] rword;
    logic [DATA_W-1:0] wdata_lane;
    logic [DATA_W-1:0] rdata_ext;
    logic [3:0]        byte_en;

    assign accept     = req_valid && req_ready;
    assign idx        = req_addr[ADDR_W-1:2];
    assign lane       = req_addr[1:0];
    assign misaligned = is_misaligned(req_size, lane);
    assign rword      = mem[idx];

    mem_lane_align u_align (
        .size        (req_size),
        .unsigned_ld (req_unsigned),
        .lane        (lane),
        .wdata       (req_wdata),
        .rword       (rword),
        .wdata_lane  (wdata_lane),
        .byte_en     (byte_en),
        .rdata_ext   (rdata_ext)
    );

    // RAM is not reset; the store commits on the acceptance edge itself.
    always_ff @(posedge clk) begin
        if (accept && req_we && !misaligned && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cnt       <= 2'd0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        cnt       <= 2'd0;
                        err_q     <= misaligned;
                        rdata_q   <= (req_we || misaligned) ? '0 : rdata_ext;
                        state     <= (LATENCY > 1) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    if (cnt == 2'(CNT_LAST)) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                RESP: begin
                    // First RESP edge raises rsp_valid, completing LATENCY edges after accept.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rdata_q;
                        rsp_err   <= err_q;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_stage.sv
// tb/tb_data_mem_stage.sv - directed bench for data_mem_stage at LATENCY 1 and 3
module tb_data_mem_stage;

    logic        clk;
    logic        rst;
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [11:0] req_addr     [2];
    logic [31:0] req_wdata    [2];
    logic        rsp_valid    [2];
    logic        rsp_ready    [2];
    logic [31:0] rsp_rdata    [2];
    logic        rsp_err      [2];

    int n_cmp;
    int n_fail;

    data_mem_stage #(.ADDR_W(12), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_stage #(.ADDR_W(12), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic we, input logic [1:0] size, input logic uns,
                               input logic [11:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err);
        vec_t r;
        r.we = we; r.size = size; r.uns = uns; r.addr = addr; r.wdata = wdata;
        r.exp_rdata = exp_rdata; r.exp_err = exp_err;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request and return when rsp_valid is seen; handshake is left to the caller.
    task automatic do_req(input int i, input logic we, input logic [1:0] size, input logic uns,
                          input logic [11:0] addr, input logic [31:0] wdata, input string tag,
                          output logic [31:0] rdata, output logic err, output int lat);
        logic ready_ok;
        ready_ok = 1'b1;
        @(negedge clk);
        req_we[i] = we; req_size[i] = size; req_unsigned[i] = uns;
        req_addr[i] = addr; req_wdata[i] = wdata; req_valid[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[i]    = 1'b0;
        req_we[i]       = ~we;
        req_addr[i]     = 12'($urandom);
        req_wdata[i]    = $urandom;
        req_size[i]     = 2'($urandom);
        req_unsigned[i] = ~uns;
        lat = 0;
        while (!rsp_valid[i] && lat < 20) begin
            if (req_ready[i]) ready_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (req_ready[i]) ready_ok = 1'b0;
        rdata = rsp_rdata[i];
        err   = rsp_err[i];
        chk({tag, " req_ready_low"}, 32'(ready_ok), 32'd1);
    endtask

    task automatic finish_rsp(input int i, input string tag);
        rsp_ready[i] = 1'b1;
        @(negedge clk);
        chk({tag, " rsp_valid_drop"}, 32'(rsp_valid[i]), 32'd0);
        chk({tag, " idle_ready"}, 32'(req_ready[i]), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        never_valid;
        logic        stable_ok;

        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_size[i] = 2'b10;
            req_unsigned[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
            rsp_ready[i] = 1'b1;
        end

        // we, size, uns, addr, wdata, expected rdata, expected err
        vecs.push_back(v(1, 2'b10, 0, 12'h010, 32'hDEADBEEF, 32'h00000000, 0));
        vecs.push_back(v(0, 2'b10, 0, 12'h010, 32'h0,        32'hDEADBEEF, 0));
        vecs.push_back(v(1, 2'b10, 0, 12'h010, 32'h00000000, 32'h00000000, 0));
        vecs.push_back(v(1, 2'b00, 0, 12'h013, 32'hABCDEF80, 32'h00000000, 0));
        vecs.push_back(v(0, 2'b00, 0, 12'h013, 32'h0,        32'hFFFFFF80, 0));
        vecs.push_back(v(0, 2'b00, 1, 12'h013, 32'h0,        32'h00000080, 0));
        vecs.push_back(v(0, 2'b10, 0, 12'h010, 32'h0,        32'h80000000, 0));
        vecs.push_back(v(1, 2'b10, 0, 12'h020, 32'hCAFEF00D, 32'h00000000, 0));
        vecs.push_back(v(0, 2'b01, 0, 12'h011, 32'h0,        32'h00000000, 1));
        vecs.push_back(v(1, 2'b10, 0, 12'h022, 32'h11111111, 32'h00000000, 1));
        vecs.push_back(v(0, 2'b10, 0, 12'h020, 32'h0,        32'hCAFEF00D, 0));
        vecs.push_back(v(0, 2'b10, 1, 12'h020, 32'h0,        32'hCAFEF00D, 0));
        vecs.push_back(v(0, 2'b00, 0, 12'h022, 32'h0,        32'hFFFFFFFE, 0));
        vecs.push_back(v(0, 2'b00, 1, 12'h021, 32'h0,        32'h000000F0, 0));
        vecs.push_back(v(0, 2'b01, 0, 12'h022, 32'h0,        32'hFFFFCAFE, 0));
        vecs.push_back(v(1, 2'b10, 0, 12'h024, 32'h00000000, 32'h00000000, 0));
        vecs.push_back(v(1, 2'b01, 0, 12'h026, 32'h1234ABCD, 32'h00000000, 0));
        vecs.push_back(v(0, 2'b01, 0, 12'h026, 32'h0,        32'hFFFFABCD, 0));
        vecs.push_back(v(0, 2'b01, 1, 12'h026, 32'h0,        32'h0000ABCD, 0));
        vecs.push_back(v(0, 2'b10, 0, 12'h024, 32'h0,        32'hABCD0000, 0));
        vecs.push_back(v(0, 2'b11, 0, 12'h024, 32'h0,        32'h00000000, 1));
        vecs.push_back(v(1, 2'b11, 0, 12'h024, 32'hFFFFFFFF, 32'h00000000, 1));
        vecs.push_back(v(1, 2'b00, 0, 12'h024, 32'h0000007F, 32'h00000000, 0));
        vecs.push_back(v(0, 2'b00, 0, 12'h024, 32'h0,        32'h0000007F, 0));
        vecs.push_back(v(0, 2'b01, 0, 12'h024, 32'h0,        32'h0000007F, 0));
        vecs.push_back(v(0, 2'b10, 0, 12'h024, 32'h0,        32'hABCD007F, 0));

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset%0d req_ready", i), 32'(req_ready[i]), 32'd1);
            chk($sformatf("reset%0d rsp_valid", i), 32'(rsp_valid[i]), 32'd0);
            chk($sformatf("reset%0d rsp_rdata", i), rsp_rdata[i], 32'd0);
            chk($sformatf("reset%0d rsp_err", i), 32'(rsp_err[i]), 32'd0);
        end
        rst = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            do_req(0, vecs[k].we, vecs[k].size, vecs[k].uns, vecs[k].addr, vecs[k].wdata,
                   tag, rd, er, lat);
            chk({tag, " latency"}, 32'(lat), 32'd1);
            chk({tag, " rdata"}, rd, vecs[k].exp_rdata);
            chk({tag, " err"}, 32'(er), 32'(vecs[k].exp_err));
            finish_rsp(0, tag);
        end

        do_req(1, 1'b1, 2'b10, 1'b0, 12'h040, 32'h55AA55AA, "l3_sw", rd, er, lat);
        chk("l3_sw latency", 32'(lat), 32'd3);
        chk("l3_sw rdata", rd, 32'd0);
        finish_rsp(1, "l3_sw");

        rsp_ready[1] = 1'b0;
        do_req(1, 1'b0, 2'b10, 1'b0, 12'h040, 32'h0, "l3_bp", rd, er, lat);
        chk("l3_bp latency", 32'(lat), 32'd3);
        chk("l3_bp rdata", rd, 32'h55AA55AA);
        stable_ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!rsp_valid[1] || rsp_rdata[1] !== 32'h55AA55AA || rsp_err[1] || req_ready[1])
                stable_ok = 1'b0;
        end
        chk("l3_bp held_stable", 32'(stable_ok), 32'd1);
        finish_rsp(1, "l3_bp");

        @(negedge clk);
        req_we[1] = 1'b1; req_size[1] = 2'b10; req_unsigned[1] = 1'b0;
        req_addr[1] = 12'h030; req_wdata[1] = 32'h12345678; req_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        never_valid = 1'b1;
        repeat (8) begin
            if (rsp_valid[1]) never_valid = 1'b0;
            @(negedge clk);
        end
        chk("abort rsp_never_valid", 32'(never_valid), 32'd1);
        chk("abort idle_ready", 32'(req_ready[1]), 32'd1);

        rsp_ready[1] = 1'b1;
        do_req(1, 1'b0, 2'b10, 1'b0, 12'h030, 32'h0, "abort_lw", rd, er, lat);
        chk("abort_lw latency", 32'(lat), 32'd3);
        chk("abort_lw rdata", rd, 32'h12345678);
        chk("abort_lw err", 32'(er), 32'd0);
        finish_rsp(1, "abort_lw");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
